clic_claim_ctrl: RTL and testbench
==================================

CLIC_CLAIM_CTRL -- requirements
Module: clic_claim_ctrl

Interface
REQ-001 Parameter: NEST_DEPTH, default 4, maximum number of nested in-service interrupts (>=1).
REQ-002 Parameters NR_INDEX_BITS and NR_PRIO_BITS SHALL be taken from common_pkg.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 arb_valid  input  1  arbiter reports a winning pending+enabled entry.
REQ-006 arb_index  input  NR_INDEX_BITS  index of the arbiter winner.
REQ-007 arb_prio  input  NR_PRIO_BITS  priority of the arbiter winner.
REQ-008 irq  output  1  interrupt offered to the core.
REQ-009 irq_index  output  NR_INDEX_BITS  index of the offered interrupt, stable while irq=1 unless re-latched per REQ-017.
REQ-010 irq_prio  output  NR_PRIO_BITS  priority of the offered interrupt.
REQ-011 claim  input  1  core accepts the offer; meaningful only while irq=1.
REQ-012 complete  input  1  core finished the innermost in-service handler.
REQ-013 clear_pending  output  1  one-cycle pulse telling pending storage to clear clear_index.
REQ-014 clear_index  output  NR_INDEX_BITS  entry to clear; valid when clear_pending=1.
REQ-015 level  output  NR_PRIO_BITS  current in-service threshold: stack top, 0 when empty.
REQ-016 depth  output  $clog2(NEST_DEPTH+1)  number of in-service entries; err_complete  output  1  one-cycle pulse on complete with empty stack.

Function
REQ-017 FSM states IDLE, OFFER, ACK; irq=1 exactly in OFFER; clear_pending=1 exactly in ACK.
REQ-018 Qualify = arb_valid AND depth<NEST_DEPTH AND (depth==0 OR arb_prio>level), strict greater-than; depth==0 qualifies any prio including 0.
REQ-019 IDLE: qualify at edge N -> OFFER, latch arb_index/arb_prio into irq_index/irq_prio; irq high in cycle N+1.
REQ-020 OFFER, claim=1: push irq_prio on stack, depth+1, clear_index<=irq_index, -> ACK; irq low and level updated the next cycle. Claim SHALL win over any simultaneous withdrawal or re-latch.
REQ-021 OFFER, no claim, not qualify: -> IDLE, irq low next cycle (offer withdrawn, nothing pushed).
REQ-022 OFFER, no claim, qualify with different arb_index or arb_prio: stay OFFER, re-latch both fields.
REQ-023 ACK lasts exactly one cycle then -> IDLE; earliest next irq is two cycles after ACK.
REQ-024 complete with depth>0 (any state): pop stack, depth-1, level becomes new top (or 0).
REQ-025 complete with depth==0: stack unchanged, err_complete=1 for the following cycle.
REQ-026 complete and claim same edge: pop applied before push; depth unchanged, top replaced by irq_prio.
REQ-027 Full (depth==NEST_DEPTH): no new offer; complete re-enables qualification on the next evaluation.
REQ-028 complete during OFFER lowers level; offer persists if still qualifying (REQ-022 applies).
REQ-029 Stack SHALL be NEST_DEPTH x NR_PRIO_BITS registers; no wrap-around, no overflow by construction.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, depth=0, stack cleared, and irq, irq_index, irq_prio, clear_pending, clear_index, level, err_complete all 0.
REQ-031 Reset during OFFER or ACK SHALL abort with no push and no clear_pending pulse; after rst_n rises, first offer no earlier than edge 1.

Verification
REQ-032 arb_valid=1, index=3, prio=2, depth 0 -> irq=1 next cycle with irq_index=3, irq_prio=2; claim -> clear_pending pulse index 3 one cycle, level=2, depth=1.
REQ-033 Nested: level=2, winner prio 2 -> no irq; winner prio 5 index 6 -> offer, claim -> level=5, depth=2; complete -> level=2, depth=1.
REQ-034 Full: NEST_DEPTH=4 claims with prio 1,2,3,4 -> winner prio 7 not offered until one complete, then offered.
REQ-035 Withdraw/re-latch: in OFFER index 3 prio 2, arbiter changes to index 9 prio 4 -> irq_index=9 next cycle; arb_valid drops -> irq=0, depth unchanged.
REQ-036 Edge events: complete at depth 0 -> err_complete one-cycle pulse; claim+complete same edge at depth 1 -> depth stays 1, level=irq_prio; rst_n low during OFFER -> all outputs 0, no clear_pending.

Source files
------------

// File: rtl/clic_claim_ctrl.sv
// CLIC claim controller: offers the arbiter winner to the core, tracks nested
// in-service priorities on a small stack and pulses pending-clear on claim.

package common_pkg;
   localparam int NR_INDEX_BITS = 6;
   localparam int NR_PRIO_BITS  = 3;
endpackage

module clic_claim_ctrl
   import common_pkg::*;
#(
   parameter int  NEST_DEPTH = 4,
   localparam int DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arb_valid,
   input  logic [NR_INDEX_BITS-1:0] arb_index,
   input  logic [NR_PRIO_BITS-1:0]  arb_prio,
   output logic                     irq,
   output logic [NR_INDEX_BITS-1:0] irq_index,
   output logic [NR_PRIO_BITS-1:0]  irq_prio,
   input  logic                     claim,
   input  logic                     complete,
   output logic                     clear_pending,
   output logic [NR_INDEX_BITS-1:0] clear_index,
   output logic [NR_PRIO_BITS-1:0]  level,
   output logic [DEPTH_W-1:0]       depth,
   output logic                     err_complete
);

   typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

   state_t                    state_q, state_d;
   logic [DEPTH_W-1:0]        depth_q, depth_pop;
   logic [NR_PRIO_BITS-1:0]   stack_q [NEST_DEPTH];
   logic [NR_PRIO_BITS-1:0]   level_c;
   logic                      qualify, pop_ok, do_latch, do_push;

   // Threshold is the top-of-stack entry, zero when nothing is in service.
   always_comb begin
      level_c = '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
         if (depth_q == DEPTH_W'(i + 1)) level_c = stack_q[i];
      end
   end

   assign qualify   = arb_valid && (depth_q < DEPTH_W'(NEST_DEPTH)) &&
                      ((depth_q == '0) || (arb_prio > level_c));
   assign pop_ok    = complete && (depth_q != '0);
   assign depth_pop = pop_ok ? depth_q - 1'b1 : depth_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      do_latch      = 1'b0;
      do_push       = 1'b0;
      irq           = 1'b0;
      clear_pending = 1'b0;
      case (state_q)
         IDLE: begin
            if (qualify) begin
               state_d  = OFFER;
               do_latch = 1'b1;
            end
         end
         OFFER: begin
            irq = 1'b1;
            // A claim takes precedence over withdrawal and re-latch.
            if (claim) begin
               state_d = ACK;
               do_push = 1'b1;
            end else if (!qualify) begin
               state_d = IDLE;
            end else if ((arb_index != irq_index) || (arb_prio != irq_prio)) begin
               do_latch = 1'b1;
            end
         end
         ACK: begin
            clear_pending = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pop is applied before push, so claim+complete replaces the top entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_q      <= '0;
         irq_index    <= '0;
         irq_prio     <= '0;
         clear_index  <= '0;
         err_complete <= 1'b0;
         for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
      end else begin
         err_complete <= complete && (depth_q == '0);
         if (do_latch) begin
            irq_index <= arb_index;
            irq_prio  <= arb_prio;
         end
         if (do_push) begin
            clear_index <= irq_index;
            depth_q     <= depth_pop + 1'b1;
         end else begin
            depth_q     <= depth_pop;
         end
         for (int i = 0; i < NEST_DEPTH; i++) begin
            if (do_push && (depth_pop == DEPTH_W'(i))) stack_q[i] <= irq_prio;
         end
      end
   end

   assign level = level_c;
   assign depth = depth_q;

endmodule

// File: tb/tb_clic_claim_ctrl.sv
// Scoreboard bench for clic_claim_ctrl: a queue-based nesting model predicts
// every cycle's outputs; a monitor compares them one edge later.

module tb_clic_claim_ctrl;
   import common_pkg::*;

   localparam int ND = 4;
   localparam int DW = $clog2(ND + 1);

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     arb_valid = 1'b0;
   logic [NR_INDEX_BITS-1:0] arb_index = '0;
   logic [NR_PRIO_BITS-1:0]  arb_prio = '0;
   logic                     claim = 1'b0;
   logic                     complete = 1'b0;
   logic                     irq;
   logic [NR_INDEX_BITS-1:0] irq_index;
   logic [NR_PRIO_BITS-1:0]  irq_prio;
   logic                     clear_pending;
   logic [NR_INDEX_BITS-1:0] clear_index;
   logic [NR_PRIO_BITS-1:0]  level;
   logic [DW-1:0]            depth;
   logic                     err_complete;

   clic_claim_ctrl #(.NEST_DEPTH(ND)) dut (
      .clk(clk), .rst_n(rst_n), .arb_valid(arb_valid), .arb_index(arb_index),
      .arb_prio(arb_prio), .irq(irq), .irq_index(irq_index), .irq_prio(irq_prio),
      .claim(claim), .complete(complete), .clear_pending(clear_pending),
      .clear_index(clear_index), .level(level), .depth(depth),
      .err_complete(err_complete)
   );

   always #5 clk = ~clk;

   typedef struct {
      int irq; int idx; int prio; int cp; int ci; int lvl; int dep; int err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   // Reference model: in-service priorities as a queue, offer as a flag.
   int   stk[$];
   bit   m_offer, m_ack;
   int   m_oi, m_op, m_ci;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(bit rv, bit av, int ai, int ap, bit cl, bit co);
      exp_t e;
      int   lvl;
      bit   qual, err;
      if (!rv) begin
         stk.delete();
         m_offer = 0; m_ack = 0; m_oi = 0; m_op = 0; m_ci = 0;
         e = '{0, 0, 0, 0, 0, 0, 0, 0};
         sb.push_back(e);
         return;
      end
      lvl  = (stk.size() > 0) ? stk[$] : 0;
      qual = av && (stk.size() < ND) && (stk.size() == 0 || ap > lvl);
      err  = co && (stk.size() == 0);
      if (co && stk.size() > 0) void'(stk.pop_back());
      if (m_ack) begin
         m_ack = 0;
      end else if (!m_offer) begin
         if (qual) begin m_offer = 1; m_oi = ai; m_op = ap; end
      end else if (cl) begin
         stk.push_back(m_op);
         m_ci = m_oi; m_ack = 1; m_offer = 0;
      end else if (!qual) begin
         m_offer = 0;
      end else begin
         m_oi = ai; m_op = ap;
      end
      e.irq  = m_offer;
      e.idx  = m_oi;
      e.prio = m_op;
      e.cp   = m_ack;
      e.ci   = m_ci;
      e.lvl  = (stk.size() > 0) ? stk[$] : 0;
      e.dep  = stk.size();
      e.err  = err;
      sb.push_back(e);
   endtask

   task automatic cyc(bit rv, bit av, int ai, int ap, bit cl, bit co);
      @(negedge clk);
      arb_valid = av;
      arb_index = NR_INDEX_BITS'(ai);
      arb_prio  = NR_PRIO_BITS'(ap);
      claim     = cl;
      complete  = co;
      rst_n     = rv;
      if (!rv) begin
         #1;
         chk("rst_irq", int'(irq), 0);
         chk("rst_clear_pending", int'(clear_pending), 0);
         chk("rst_depth", int'(depth), 0);
         chk("rst_level", int'(level), 0);
         chk("rst_irq_index", int'(irq_index), 0);
         chk("rst_irq_prio", int'(irq_prio), 0);
         chk("rst_clear_index", int'(clear_index), 0);
         chk("rst_err_complete", int'(err_complete), 0);
      end
      model_step(rv, av, ai, ap, cl, co);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("irq", int'(irq), mon_e.irq);
            if (mon_e.irq != 0) begin
               chk("irq_index", int'(irq_index), mon_e.idx);
               chk("irq_prio", int'(irq_prio), mon_e.prio);
            end
            chk("clear_pending", int'(clear_pending), mon_e.cp);
            if (mon_e.cp != 0) chk("clear_index", int'(clear_index), mon_e.ci);
            chk("level", int'(level), mon_e.lvl);
            chk("depth", int'(depth), mon_e.dep);
            chk("err_complete", int'(err_complete), mon_e.err);
         end
      end
   end

   initial begin
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
      // Basic offer/claim at depth 0
      cyc(1, 1, 3, 2, 0, 0);
      cyc(1, 1, 3, 2, 1, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      // Nesting: equal priority blocked, higher offered
      repeat (3) cyc(1, 1, 4, 2, 0, 0);
      cyc(1, 1, 6, 5, 0, 0);
      cyc(1, 1, 6, 5, 1, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 1);
      // Fill the stack with 1..4, then prio 7 waits for a complete
      for (int p = 1; p <= 4; p++) begin
         cyc(1, 1, p, p, 0, 0);
         cyc(1, 1, p, p, 1, 0);
         cyc(1, 0, 0, 0, 0, 0);
      end
      repeat (4) cyc(1, 1, 7, 7, 0, 0);
      cyc(1, 1, 7, 7, 0, 1);
      repeat (2) cyc(1, 1, 7, 7, 0, 0);
      cyc(1, 1, 7, 7, 1, 0);
      cyc(1, 0, 0, 0, 0, 0);
      repeat (4) cyc(1, 0, 0, 0, 0, 1);
      // Re-latch then withdraw
      cyc(1, 1, 3, 2, 0, 0);
      cyc(1, 1, 9, 4, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      // Complete on empty stack
      cyc(1, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0);
      // Claim and complete on the same edge at depth 1
      cyc(1, 1, 1, 1, 0, 0);
      cyc(1, 1, 1, 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 5, 6, 0, 0);
      cyc(1, 1, 5, 6, 1, 1);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      // Reset in the middle of an offer, claim asserted
      cyc(1, 1, 2, 7, 0, 0);
      cyc(0, 1, 2, 7, 1, 0);
      cyc(0, 1, 2, 7, 1, 0);
      cyc(1, 1, 2, 7, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(199) != 0),
             ($urandom_range(9) < 7),
             int'($urandom_range(63)),
             int'($urandom_range(7)),
             ($urandom_range(9) < 3),
             ($urandom_range(99) < 12));
      end
      cyc(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
